// File: rtl/pmem_sched_if.sv
// ----------------------------------------------------------------------------
// pmem_sched_if: cache-side and memory-side cacheline bus of pmem_sched.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface pmem_sched_if #(
  parameter int s_offset = 4,
  parameter int size     = (2**s_offset)*8
);
  logic [31:0]     i_pmem_address;
  logic            i_pmem_read;
  logic [size-1:0] i_pmem_rdata;
  logic            i_pmem_resp;

  logic [31:0]     d_pmem_address;
  logic            d_pmem_read;
  logic            d_pmem_write;
  logic [size-1:0] d_pmem_wdata;
  logic [size-1:0] d_pmem_rdata;
  logic            d_pmem_resp;

  logic [size-1:0] pmem_rdata_c;
  logic            pmem_resp_c;
  logic [31:0]     pmem_address_c;
  logic            pmem_read_c;
  logic            pmem_write_c;
  logic [size-1:0] pmem_wdata_c;

  // Environment side: caches issue requests, memory returns responses.
  modport master (
    output i_pmem_address, i_pmem_read, d_pmem_address, d_pmem_read,
           d_pmem_write, d_pmem_wdata, pmem_rdata_c, pmem_resp_c,
    input  i_pmem_rdata, i_pmem_resp, d_pmem_rdata, d_pmem_resp,
           pmem_address_c, pmem_read_c, pmem_write_c, pmem_wdata_c
  );

  // Scheduler side.
  modport slave (
    input  i_pmem_address, i_pmem_read, d_pmem_address, d_pmem_read,
           d_pmem_write, d_pmem_wdata, pmem_rdata_c, pmem_resp_c,
    output i_pmem_rdata, i_pmem_resp, d_pmem_rdata, d_pmem_resp,
           pmem_address_c, pmem_read_c, pmem_write_c, pmem_wdata_c
  );
endinterface

`default_nettype wire

// File: rtl/pmem_sched.sv
// ----------------------------------------------------------------------------
// pmem_sched: grants the shared cacheline memory port to the I- or D-cache one
// transaction at a time. Define PMEM_SCHED_RR_EN for round-robin tie-breaking.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pmem_sched #(
  parameter int s_offset = 4,
  parameter int size     = (2**s_offset)*8
) (
  input  logic         clk,
  input  logic         rst_n,
  pmem_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    I_RD    = 3'd1,
    D_RD    = 3'd2,
    D_WR    = 3'd3,
    RECOVER = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [31:0]     addr_q;
  logic [size-1:0] wdata_q;
  logic            d_req;
  logic            i_req;
  logic            grant_d;
  logic            busy;

  assign d_req = bus.d_pmem_read | bus.d_pmem_write;
  assign i_req = bus.i_pmem_read;
  assign busy  = (state == I_RD) || (state == D_RD) || (state == D_WR);

`ifdef PMEM_SCHED_RR_EN
  // Set when the most recent completed transaction belonged to the D-cache.
  logic last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d <= 1'b0;
    end else if (busy && bus.pmem_resp_c) begin
      last_d <= (state == D_RD) || (state == D_WR);
    end
  end

  assign grant_d = d_req & (~i_req | ~last_d);
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Winner's address (and writeback data) is frozen for the whole transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE) begin
      if (grant_d) begin
        addr_q <= bus.d_pmem_address;
        if (!bus.d_pmem_read) begin
          wdata_q <= bus.d_pmem_wdata;
        end
      end else if (i_req) begin
        addr_q <= bus.i_pmem_address;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_nx = bus.d_pmem_read ? D_RD : D_WR;
        end else if (i_req) begin
          state_nx = I_RD;
        end
      end
      I_RD, D_RD, D_WR: begin
        if (bus.pmem_resp_c) begin
          state_nx = RECOVER;
        end
      end
      RECOVER: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.pmem_address_c = '0;
    bus.pmem_read_c    = 1'b0;
    bus.pmem_write_c   = 1'b0;
    bus.pmem_wdata_c   = '0;
    bus.i_pmem_resp    = 1'b0;
    bus.i_pmem_rdata   = '0;
    bus.d_pmem_resp    = 1'b0;
    bus.d_pmem_rdata   = '0;
    case (state)
      I_RD: begin
        bus.pmem_address_c = addr_q;
        bus.pmem_read_c    = 1'b1;
        bus.i_pmem_resp    = bus.pmem_resp_c;
        bus.i_pmem_rdata   = bus.pmem_resp_c ? bus.pmem_rdata_c : '0;
      end
      D_RD: begin
        bus.pmem_address_c = addr_q;
        bus.pmem_read_c    = 1'b1;
        bus.d_pmem_resp    = bus.pmem_resp_c;
        bus.d_pmem_rdata   = bus.pmem_resp_c ? bus.pmem_rdata_c : '0;
      end
      D_WR: begin
        bus.pmem_address_c = addr_q;
        bus.pmem_write_c   = 1'b1;
        bus.pmem_wdata_c   = wdata_q;
        bus.d_pmem_resp    = bus.pmem_resp_c;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_pmem_sched.sv
// ----------------------------------------------------------------------------
// tb_pmem_sched: directed stimulus with a per-cycle transaction-level model.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pmem_sched;
  localparam int SO = 4;
  localparam int SZ = (2**SO)*8;
`ifdef PMEM_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pmem_sched_if #(.s_offset(SO), .size(SZ)) bus();
  pmem_sched #(.s_offset(SO), .size(SZ)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input logic [SZ-1:0] act, input logic [SZ-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Transaction model: who owns the port, what was captured, recovery gap left.
  int          m_owner  = 0;   // 0 none, 1 I-cache, 2 D-cache
  bit          m_wr     = 1'b0;
  logic [31:0] m_addr   = '0;
  logic [SZ-1:0] m_data = '0;
  int          m_gap    = 0;
  bit          m_last_d = 1'b0;
  logic        m_dq;
  logic        m_iq;
  assign m_dq = bus.d_pmem_read | bus.d_pmem_write;
  assign m_iq = bus.i_pmem_read;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= 0; m_wr <= 1'b0; m_addr <= '0; m_data <= '0; m_gap <= 0; m_last_d <= 1'b0;
    end else if (m_owner != 0) begin
      if (bus.pmem_resp_c) begin
        m_last_d <= (m_owner == 2);
        m_owner  <= 0;
        m_gap    <= 1;
      end
    end else if (m_gap > 0) begin
      m_gap <= m_gap - 1;
    end else if (m_dq && (!m_iq || !RR || !m_last_d)) begin
      m_owner <= 2;
      m_wr    <= !bus.d_pmem_read;
      m_addr  <= bus.d_pmem_address;
      m_data  <= bus.d_pmem_wdata;
    end else if (m_iq) begin
      m_owner <= 1;
      m_addr  <= bus.i_pmem_address;
    end
  end

  logic          e_read, e_write, e_iresp, e_dresp;
  logic [31:0]   e_addr;
  logic [SZ-1:0] e_wdata, e_irdata, e_drdata;
  assign e_read   = (m_owner == 1) || (m_owner == 2 && !m_wr);
  assign e_write  = (m_owner == 2) && m_wr;
  assign e_addr   = (m_owner != 0) ? m_addr : 32'h0;
  assign e_wdata  = e_write ? m_data : '0;
  assign e_iresp  = (m_owner == 1) && bus.pmem_resp_c;
  assign e_dresp  = (m_owner == 2) && bus.pmem_resp_c;
  assign e_irdata = e_iresp ? bus.pmem_rdata_c : '0;
  assign e_drdata = (e_dresp && !m_wr) ? bus.pmem_rdata_c : '0;

  always @(negedge clk) begin
    if (rst_n) begin
      check("pmem_read_c",    SZ'(bus.pmem_read_c),    SZ'(e_read));
      check("pmem_write_c",   SZ'(bus.pmem_write_c),   SZ'(e_write));
      check("pmem_address_c", SZ'(bus.pmem_address_c), SZ'(e_addr));
      check("pmem_wdata_c",   bus.pmem_wdata_c,        e_wdata);
      check("i_pmem_resp",    SZ'(bus.i_pmem_resp),    SZ'(e_iresp));
      check("d_pmem_resp",    SZ'(bus.d_pmem_resp),    SZ'(e_dresp));
      check("i_pmem_rdata",   bus.i_pmem_rdata,        e_irdata);
      check("d_pmem_rdata",   bus.d_pmem_rdata,        e_drdata);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_strobe(input string name);
    int b = 0;
    while (!(bus.pmem_read_c || bus.pmem_write_c) && b < 20) begin step(); b++; end
    if (b >= 20) check({name, "_timeout"}, '0, SZ'(1));
  endtask

  // Acts as memory: waits for a strobe, answers after lat busy cycles.
  task automatic mem_serve(input int lat, input logic [SZ-1:0] data, output logic [31:0] addr,
                           output int hi, output logic ir, output logic dr, output logic [SZ-1:0] rd);
    hi = 0;
    wait_strobe("serve");
    addr = bus.pmem_address_c;
    repeat (lat - 1) begin
      if (bus.pmem_read_c || bus.pmem_write_c) hi++;
      step();
    end
    if (bus.pmem_read_c || bus.pmem_write_c) hi++;
    bus.pmem_resp_c = 1'b1; bus.pmem_rdata_c = data;
    #2;
    ir = bus.i_pmem_resp; dr = bus.d_pmem_resp; rd = bus.i_pmem_rdata | bus.d_pmem_rdata;
    step();
    bus.pmem_resp_c = 1'b0; bus.pmem_rdata_c = '0;
  endtask

  logic [31:0]   a1, a2;
  int            h1, h2;
  logic          ir1, dr1, ir2, dr2;
  logic [SZ-1:0] rd1, rd2;
  logic [SZ-1:0] w1, w2, pat_a5;

  initial begin
    w1     = {4{32'hDEAD_BEEF}};
    w2     = {4{32'h1234_5678}};
    pat_a5 = {16{8'hA5}};
    bus.i_pmem_address = '0; bus.i_pmem_read = 1'b0;
    bus.d_pmem_address = '0; bus.d_pmem_read = 1'b0; bus.d_pmem_write = 1'b0; bus.d_pmem_wdata = '0;
    bus.pmem_rdata_c = '0; bus.pmem_resp_c = 1'b0;
    step();
    check("reset_read",  SZ'(bus.pmem_read_c),    '0);
    check("reset_write", SZ'(bus.pmem_write_c),   '0);
    check("reset_addr",  SZ'(bus.pmem_address_c), '0);
    step();
    rst_n = 1'b1;
    step();

    // Single I-cache read, 3-cycle memory latency.
    bus.i_pmem_read = 1'b1; bus.i_pmem_address = 32'h0000_0040;
    mem_serve(3, pat_a5, a1, h1, ir1, dr1, rd1);
    bus.i_pmem_read = 1'b0;
    check("i_addr",      SZ'(a1),  SZ'(32'h0000_0040));
    check("i_strobe_hi", SZ'(h1),  SZ'(3));
    check("i_resp",      SZ'(ir1), SZ'(1));
    check("i_d_resp",    SZ'(dr1), '0);
    check("i_rdata",     rd1,      pat_a5);

    // D-cache writeback; input data changes mid-transaction.
    bus.d_pmem_write = 1'b1; bus.d_pmem_address = 32'h0000_1000; bus.d_pmem_wdata = w1;
    wait_strobe("dwr");
    step();
    bus.d_pmem_wdata = w2;
    step();
    check("dwr_addr",  SZ'(bus.pmem_address_c), SZ'(32'h0000_1000));
    check("dwr_wdata", bus.pmem_wdata_c, w1);
    bus.pmem_resp_c = 1'b1; bus.pmem_rdata_c = w2;
    #2;
    check("dwr_resp",  SZ'(bus.d_pmem_resp), SZ'(1));
    check("dwr_rdata", bus.d_pmem_rdata, '0);
    step();
    bus.pmem_resp_c = 1'b0; bus.pmem_rdata_c = '0; bus.d_pmem_write = 1'b0;
    check("dwr_drop", SZ'(bus.pmem_write_c), '0);

    // Two simultaneous I/D read pairs; D was served last before the first pair.
    for (int k = 0; k < 2; k++) begin
      bus.i_pmem_read = 1'b1; bus.i_pmem_address = 32'h0000_2000 + 32'(k) * 32'h100;
      bus.d_pmem_read = 1'b1; bus.d_pmem_address = 32'h0000_3000 + 32'(k) * 32'h100;
      mem_serve(1, w1, a1, h1, ir1, dr1, rd1);
      if (dr1) bus.d_pmem_read = 1'b0;
      if (ir1) bus.i_pmem_read = 1'b0;
      mem_serve(2, w2, a2, h2, ir2, dr2, rd2);
      bus.d_pmem_read = 1'b0; bus.i_pmem_read = 1'b0;
      check("pair_first_addr",  SZ'(a1), SZ'(RR ? 32'h0000_2000 + 32'(k) * 32'h100
                                                : 32'h0000_3000 + 32'(k) * 32'h100));
      check("pair_second_addr", SZ'(a2), SZ'(RR ? 32'h0000_3000 + 32'(k) * 32'h100
                                                : 32'h0000_2000 + 32'(k) * 32'h100));
      check("pair_first_rdata", rd1, w1);
    end

    // Read and write together: read wins.
    bus.d_pmem_read = 1'b1; bus.d_pmem_write = 1'b1; bus.d_pmem_address = 32'h0000_4000; bus.d_pmem_wdata = w1;
    wait_strobe("rdwr");
    check("rdwr_read",  SZ'(bus.pmem_read_c),  SZ'(1));
    check("rdwr_write", SZ'(bus.pmem_write_c), '0);
    bus.pmem_resp_c = 1'b1; bus.pmem_rdata_c = w2;
    step();
    bus.pmem_resp_c = 1'b0; bus.pmem_rdata_c = '0; bus.d_pmem_read = 1'b0; bus.d_pmem_write = 1'b0;
    step();

    // Asynchronous reset in the middle of a D read.
    bus.d_pmem_read = 1'b1; bus.d_pmem_address = 32'h0000_5000;
    wait_strobe("rst");
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_read",  SZ'(bus.pmem_read_c),    '0);
    check("rst_write", SZ'(bus.pmem_write_c),   '0);
    check("rst_addr",  SZ'(bus.pmem_address_c), '0);
    check("rst_dresp", SZ'(bus.d_pmem_resp),    '0);
    bus.d_pmem_read = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("post_rst_read", SZ'(bus.pmem_read_c), '0);

    // Spurious memory response while idle.
    bus.pmem_resp_c = 1'b1; bus.pmem_rdata_c = w1;
    #2;
    check("spur_iresp", SZ'(bus.i_pmem_resp), '0);
    check("spur_dresp", SZ'(bus.d_pmem_resp), '0);
    step();
    bus.pmem_resp_c = 1'b0; bus.pmem_rdata_c = '0;
    check("spur_read", SZ'(bus.pmem_read_c), '0);
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

`default_nettype wire
